// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Initiator side of the instruction-memory read path. Holds the fetch PC,
//   drives the word index into a combinational instruction memory, captures
//   {pc, inst} pairs into a small prefetch FIFO and presents the FIFO head to
//   decode. Execute can redirect the PC, which flushes the FIFO. Fetching
//   stops (FAULT state) when the PC leaves the memory range.
//
// Ports
//   clk            in   system clock, all state on rising edge
//   rst            in   synchronous active-high reset
//   Dir            out  word index to memory = fetch_pc[31:2]
//   Inst           in   instruction word returned for Dir, same cycle
//   out_valid      out  FIFO head holds a valid instruction
//   out_ready      in   decode accepts the head this cycle
//   out_inst       out  head instruction (0 when empty)
//   out_pc         out  head byte address (0 when empty)
//   redirect_valid in   execute requests a PC change
//   redirect_pc    in   new byte address, bits [1:0] ignored
//   fault          out  fetch stopped on out-of-range address
//   dbg_state      out  FSM state (0 = RUN, 1 = FAULT)
//
// Handshake: the head transfers on a rising edge where out_valid && out_ready
//   are both high. Once raised, out_valid stays high with stable out_inst and
//   out_pc until the head is transferred or flushed by redirect or rst. A
//   redirect in the same cycle discards the head instead of transferring it.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_WORDS  = 128,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] Dir,
  input  logic [31:0] Inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic        dbg_state
);

  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // State
  state_t         state_q, state_d;
  logic           fault_q, fault_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    pc_mem_q   [FIFO_DEPTH];
  logic [31:0]    inst_mem_q [FIFO_DEPTH];

  // Per-cycle decisions
  logic pop;
  logic slot_free;
  logic try_push;
  logic in_range;
  logic push;

  // Low address bits of the redirect target are intentionally dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign Dir       = {2'b00, fetch_pc_q[31:2]};
  assign out_valid = (count_q != '0);
  assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign fault     = fault_q;
  assign dbg_state = state_q;

  always_comb begin
    pop       = out_valid & out_ready & ~redirect_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still streams.
    slot_free = (count_q < DEPTH_C) | pop;
    try_push  = (state_q == ST_RUN) & slot_free & ~redirect_valid;
    in_range  = (fetch_pc_q[31:2] < MEM_WORDS_W);
    push      = try_push & in_range;

    state_d    = state_q;
    fault_d    = fault_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      // Redirect overrides push, pop and fault.
      state_d    = ST_RUN;
      fault_d    = 1'b0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      // The offending word is never pushed; the PC holds on it.
      if (try_push && !in_range) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fault_q    <= 1'b0;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        inst_mem_q[wr_ptr_q] <= Inst;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Dir;
  logic [31:0] Inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic        dbg_state;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .MEM_WORDS  (128),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Dir            (Dir),
    .Inst           (Inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .dbg_state      (dbg_state)
  );

  // Instruction memory: mem[i] = 0x1000_0000 + i
  logic [31:0] mem [0:127];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
  end
  always_comb begin
    Inst = 32'hDEAD_BEEF;
    if (Dir < 32'd128) Inst = mem[Dir[6:0]];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  // Monitor: every real transfer must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: got pc=%h inst=%h expected none", out_pc, out_inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_inst} !== e) begin
          errors++;
          $display("FAIL transfer: got pc=%h inst=%h expected pc=%h inst=%h",
                   out_pc, out_inst, e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run until the scoreboard drains; returns cycles used.
  task automatic drain(input string name, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pc",    out_pc,   32'h0);
    check("rst_inst",  out_inst, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_dir",   Dir,      32'd0);

    // Release with decode stalled: head valid one cycle later, FIFO fills.
    rst = 1'b0;
    step();
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_pc",    out_pc,   32'h0);
    check("first_inst",  out_inst, 32'h1000_0000);
    step(); step(); step(); step();
    check("stall_valid", {31'b0, out_valid}, 32'd1);
    check("stall_pc",    out_pc,   32'h0);
    check("stall_dir",   Dir,      32'd2);

    // Full-rate streaming: eight transfers in eight cycles, in order.
    for (int i = 0; i < 8; i++) expect_out(32'(i * 4), 32'h1000_0000 + 32'(i));
    out_ready = 1'b1;
    drain("stream", 20, cyc);
    check("stream_cycles", 32'(cyc), 32'd8);
    out_ready = 1'b0;
    check("stream_head_pc", out_pc, 32'h20);

    // Redirect while the head is offered: head discarded, not transferred.
    out_ready = 1'b1;
    redirect(32'h0000_0043);
    check("redir_valid", {31'b0, out_valid}, 32'd0);
    check("redir_dir",   Dir, 32'd16);
    expect_out(32'h40, 32'h1000_0010);
    expect_out(32'h44, 32'h1000_0011);
    expect_out(32'h48, 32'h1000_0012);
    step();
    check("redir_head_pc",   out_pc,   32'h40);
    check("redir_head_inst", out_inst, 32'h1000_0010);
    drain("redir", 20, cyc);
    out_ready = 1'b0;

    // Run off the end of memory.
    out_ready = 1'b1;
    redirect(32'h0000_01F8);
    expect_out(32'h1F8, 32'h1000_007E);
    expect_out(32'h1FC, 32'h1000_007F);
    drain("edge", 20, cyc);
    step();
    check("fault_flag",  {31'b0, fault},     32'd1);
    check("fault_state", {31'b0, dbg_state}, 32'd1);
    check("fault_valid", {31'b0, out_valid}, 32'd0);
    check("fault_dir",   Dir, 32'd128);
    step(); step(); step();
    check("fault_hold_valid", {31'b0, out_valid}, 32'd0);
    check("fault_hold_dir",   Dir, 32'd128);

    // Leave FAULT through redirect.
    redirect(32'h0000_0010);
    check("recover_fault", {31'b0, fault}, 32'd0);
    check("recover_valid", {31'b0, out_valid}, 32'd0);
    expect_out(32'h10, 32'h1000_0004);
    drain("recover", 20, cyc);
    out_ready = 1'b0;

    // Wrap boundary: 0xFFFF_FFFC is out of range, faults without pushing.
    redirect(32'hFFFF_FFFC);
    step();
    check("wrap_fault", {31'b0, fault},     32'd1);
    check("wrap_valid", {31'b0, out_valid}, 32'd0);
    check("wrap_dir",   Dir, 32'h3FFF_FFFF);

    // Reset beats a simultaneous redirect on a full FIFO.
    redirect(32'h0000_0000);
    step(); step(); step();
    check("full_valid", {31'b0, out_valid}, 32'd1);
    check("full_dir",   Dir, 32'd2);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1;
    step();
    check("rstmid_valid", {31'b0, out_valid}, 32'd0);
    check("rstmid_dir",   Dir, 32'd0);
    check("rstmid_fault", {31'b0, fault}, 32'd0);
    check("rstmid_pc",    out_pc, 32'h0);
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    step();
    check("rstmid_first_pc",   out_pc,   32'h0);
    check("rstmid_first_inst", out_inst, 32'h1000_0000);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
